mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage consuming the load/store fields that the ID/EX pipeline register delivers to the execute side: `ld_type`, `read_addr`, `ram_wreg`, `ram_waddr`, plus the EX result. It drives a request/acknowledge data-RAM port and stalls the pipeline until the access completes. It also performs byte-lane steering and load sign/zero extension. It registers the writeback triple `(waddr, wreg, wdata)` toward the MEM/WB boundary.

## Interface
Parameters:
- `DataW`, 32: data and address width (`RegBus`).
- `RegAW`, 5: register address width (`RegAddrBus`).

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset (`RstEnable` = 1'b1).
- `ex_waddr`  in  5  destination register.
- `ex_wreg`  in  1  register write enable.
- `ex_wdata`  in  32  ALU result, used when no load is pending.
- `ex_ld_type`  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, 111 none; other codes are treated as none.
- `ex_read_addr`  in  32  load byte address.
- `ex_ram_wreg`  in  1  store request.
- `ex_ram_waddr`  in  32  store byte address.
- `ex_ram_wdata`  in  32  store data (rs2).
- `ex_st_type`  in  2  00 SB, 01 SH, 10 SW; 11 is treated as SW.
- `stall_req`  out  1  combinational; holds upstream stages.
- `dram_req`  out  1  request, held until acknowledged.
- `dram_we`  out  1  1 = write.
- `dram_addr`  out  32  word-aligned address (`[1:0]` = 00).
- `dram_be`  out  4  byte enables.
- `dram_wdata`  out  32  lane-replicated store data.
- `dram_rdata`  in  32  read word, valid in the ack cycle.
- `dram_ack`  in  1  one-cycle completion.
- `mem_waddr`, `mem_wreg`, `mem_wdata`  out  5/1/32  registered writeback.
- `misalign`  out  1  registered one-cycle fault pulse.

## Operation
- `ld_op` = (`ex_ld_type` is a valid load); `st_op` = `ex_ram_wreg` & !`ld_op`. If both a load and a store are presented, the load wins.
- Alignment rules:
  - Halfword accesses need `addr[0]`=0.
  - Word accesses need `addr[1:0]`=0.
  - A misaligned access issues no DRAM request and raises no stall. Next edge: `misalign`=1, `mem_wreg`=0.
- FSM states are IDLE and BUSY.
- IDLE:
  - With an aligned `ld_op` or `st_op`, the next edge latches `we`, word address, `be`, wdata, `ld_type` and `addr[1:0]`, captures `waddr`/`wreg`, and moves to BUSY.
  - Otherwise the next edge passes `ex_*` through to `mem_*`.
- BUSY:
  - `dram_req`=1 with latched fields stable.
  - Each cycle without ack: `mem_wreg`=0 (bubble).
  - On `dram_ack`, the next edge writes `mem_*`, returns to IDLE and drops `dram_req`.
  - For a load: `mem_wdata` = extended `dram_rdata` lane, and `mem_wreg` = captured `wreg`.
  - For a store: `mem_wreg`=0.
- `stall_req` = (IDLE & aligned mem op) | (BUSY & !`dram_ack`). Upstream holds `ex_*` stable while it is high.
- Byte enables:
  - SB: 0001 << `addr[1:0]`.
  - SH: 0011 << `addr[1:0]`.
  - SW: 1111.
  - Loads: the same masks by size.
- Store data replication: SB {4{b[7:0]}}, SH {2{h[15:0]}}, SW word.
- Load extraction:
  - Lane = `rdata` >> (8·`addr[1:0]`).
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
- Reset:
  - FSM to IDLE; `dram_req`, `dram_we`, `mem_wreg`, `misalign` = 0.
  - `dram_addr`, `dram_be`, `dram_wdata`, `mem_wdata` = 0; `mem_waddr` = `NOPRegAddr`.
  - A reset during BUSY abandons the access. An ack arriving in IDLE is ignored.

## Timing
- Non-memory op: 1-cycle register latency and no stall.
- Memory op presented in cycle t:
  - `stall_req`=1 in cycle t.
  - `dram_req` rises at t+1.
  - If ack arrives in cycle t+k (k≥1), `stall_req` is high for cycles t..t+k-1 and low in t+k.
  - `mem_*` is valid at t+k+1; minimum latency is 2 cycles.
- `dram_req` never drops before ack. Address, `be`, `we` and wdata do not change while `dram_req` is high.
- Back-to-back memory ops: the second is accepted in the cycle after ack, when IDLE and `stall_req` is re-evaluated.

## Structure
- Shared `defines.v` gains `LD_LB`, `LD_LH`, `LD_LW`, `LD_LBU`, `LD_LHU`, `LD_NONE` (3'b111), `ST_SB`, `ST_SH`, `ST_SW`, and the state encodings. It reuses `RstEnable`, `ZeroWord`, `NOPRegAddr`, `WriteDisable`.
- One natural sub-module: `load_extend`, combinational (`rdata`, `addr[1:0]`, `ld_type`) → 32-bit result.

## Test plan
- ALU pass-through: `ex_wreg`=1, `waddr`=5, `wdata`=0x1234, `ld_type`=111. Next edge: `mem_*` = (5, 1, 0x1234); `stall_req` never asserts.
- LB at 0x103, `rdata`=0x80FF_0011, ack 3 cycles after req:
  - `dram_addr`=0x100, `be`=1000.
  - `stall_req` high until the ack cycle.
  - `mem_wdata`=0xFFFF_FF80.
  - LBU instead gives 0x0000_0080.
- SH at 0x202, data 0xABCD_5678: `be`=1100, `dram_wdata`=0x5678_5678, `we`=1, `mem_wreg`=0 after ack.
- LW at 0x305 (misaligned): no `dram_req`; `misalign` pulses 1 cycle; `mem_wreg`=0.
- Reset in BUSY before ack: `dram_req`=0 next cycle. A later ack produces no `mem_wreg` and no state change.
- Back-to-back SW to 0x10 then LW from 0x10 with ack=1 each request:
  - Two request phases, each holding fields stable.
  - LW returns the memory model's 0xDEAD_BEEF.

Source files
------------

// File: rtl/mem_access_pkg.sv
// ============================================================================
// mem_access_pkg : shared constants, load/store codes and helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_access_pkg;

  localparam logic        RST_ENABLE    = 1'b1;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic [4:0]  NOP_REG_ADDR  = 5'b00000;
  localparam logic        WRITE_DISABLE = 1'b0;

  localparam logic [2:0] LD_LB   = 3'b000;
  localparam logic [2:0] LD_LH   = 3'b001;
  localparam logic [2:0] LD_LW   = 3'b010;
  localparam logic [2:0] LD_LBU  = 3'b100;
  localparam logic [2:0] LD_LHU  = 3'b101;
  localparam logic [2:0] LD_NONE = 3'b111;

  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  function automatic logic is_load(input logic [2:0] t);
    case (t)
      LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU: is_load = 1'b1;
      default:                             is_load = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_mask(input size_t sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: byte_mask = 4'b0001 << off;
      SZ_HALF: byte_mask = 4'b0011 << off;
      default: byte_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic is_aligned(input size_t sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: is_aligned = 1'b1;
      SZ_HALF: is_aligned = ~off[0];
      default: is_aligned = (off == 2'b00);
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_load_extend.sv
// ============================================================================
// mem_access_load_extend : picks the addressed lane of a read word and
// sign/zero-extends it according to the load type
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_access_load_extend
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  ld_type,
  output logic [31:0] result
);

  logic [15:0] lane;

  always_comb begin
    lane = 16'(rdata >> {offset, 3'b000});
    case (ld_type)
      LD_LB:   result = {{24{lane[7]}}, lane[7:0]};
      LD_LH:   result = {{16{lane[15]}}, lane[15:0]};
      LD_LBU:  result = {24'h000000, lane[7:0]};
      LD_LHU:  result = {16'h0000, lane[15:0]};
      default: result = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
// ============================================================================
// mem_access : memory-access stage with req/ack data-RAM port, pipeline stall,
// byte-lane steering and registered writeback toward MEM/WB
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_access
  import mem_access_pkg::*;
#(
  parameter int DataW = 32,
  parameter int RegAW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RegAW-1:0] ex_waddr,
  input  logic             ex_wreg,
  input  logic [DataW-1:0] ex_wdata,
  input  logic [2:0]       ex_ld_type,
  input  logic [DataW-1:0] ex_read_addr,
  input  logic             ex_ram_wreg,
  input  logic [DataW-1:0] ex_ram_waddr,
  input  logic [DataW-1:0] ex_ram_wdata,
  input  logic [1:0]       ex_st_type,
  output logic             stall_req,
  output logic             dram_req,
  output logic             dram_we,
  output logic [DataW-1:0] dram_addr,
  output logic [3:0]       dram_be,
  output logic [DataW-1:0] dram_wdata,
  input  logic [DataW-1:0] dram_rdata,
  input  logic             dram_ack,
  output logic [RegAW-1:0] mem_waddr,
  output logic             mem_wreg,
  output logic [DataW-1:0] mem_wdata,
  output logic             misalign
);

  state_t           state;
  logic             ld_op;
  logic             st_op;
  logic             mem_op;
  logic             aligned;
  size_t            size;
  logic [DataW-1:0] addr;
  logic [3:0]       be;
  logic [DataW-1:0] st_data;
  logic [2:0]       ld_type_q;
  logic [1:0]       offset_q;
  logic [RegAW-1:0] waddr_q;
  logic             wreg_q;
  logic [DataW-1:0] ld_result;

  always_comb begin
    ld_op  = is_load(ex_ld_type);
    st_op  = ex_ram_wreg & ~ld_op;
    mem_op = ld_op | st_op;
    addr   = ld_op ? ex_read_addr : ex_ram_waddr;
    size   = SZ_WORD;
    if (ld_op) begin
      case (ex_ld_type[1:0])
        2'b00:   size = SZ_BYTE;
        2'b01:   size = SZ_HALF;
        default: size = SZ_WORD;
      endcase
    end else begin
      case (ex_st_type)
        ST_SB:   size = SZ_BYTE;
        ST_SH:   size = SZ_HALF;
        ST_SW:   size = SZ_WORD;
        default: size = SZ_WORD;
      endcase
    end
    aligned = is_aligned(size, addr[1:0]);
    be      = byte_mask(size, addr[1:0]);
    case (size)
      SZ_BYTE: st_data = {4{ex_ram_wdata[7:0]}};
      SZ_HALF: st_data = {2{ex_ram_wdata[15:0]}};
      default: st_data = ex_ram_wdata;
    endcase
  end

  // Combinational so upstream freezes in the very cycle the op is presented.
  assign stall_req = ((state == S_IDLE) & mem_op & aligned) |
                     ((state == S_BUSY) & ~dram_ack);

  mem_access_load_extend u_load_extend (
    .rdata   (dram_rdata),
    .offset  (offset_q),
    .ld_type (ld_type_q),
    .result  (ld_result)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state      <= S_IDLE;
      dram_req   <= 1'b0;
      dram_we    <= WRITE_DISABLE;
      dram_addr  <= ZERO_WORD;
      dram_be    <= 4'b0000;
      dram_wdata <= ZERO_WORD;
      ld_type_q  <= LD_NONE;
      offset_q   <= 2'b00;
      waddr_q    <= NOP_REG_ADDR;
      wreg_q     <= WRITE_DISABLE;
      mem_waddr  <= NOP_REG_ADDR;
      mem_wreg   <= WRITE_DISABLE;
      mem_wdata  <= ZERO_WORD;
      misalign   <= 1'b0;
    end else begin
      misalign <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mem_op && aligned) begin
            state      <= S_BUSY;
            dram_req   <= 1'b1;
            dram_we    <= st_op;
            dram_addr  <= {addr[DataW-1:2], 2'b00};
            dram_be    <= be;
            dram_wdata <= st_data;
            ld_type_q  <= ld_op ? ex_ld_type : LD_NONE;
            offset_q   <= addr[1:0];
            waddr_q    <= ex_waddr;
            wreg_q     <= ex_wreg;
            mem_wreg   <= WRITE_DISABLE;
          end else begin
            // Misaligned memory ops fall through here as a write-suppressed bubble.
            mem_waddr <= ex_waddr;
            mem_wdata <= ex_wdata;
            mem_wreg  <= ex_wreg & ~mem_op;
            misalign  <= mem_op;
          end
        end
        S_BUSY: begin
          if (dram_ack) begin
            state     <= S_IDLE;
            dram_req  <= 1'b0;
            dram_we   <= WRITE_DISABLE;
            mem_waddr <= waddr_q;
            mem_wreg  <= wreg_q & ~dram_we;
            if (!dram_we) begin
              mem_wdata <= ld_result;
            end
          end else begin
            mem_wreg <= WRITE_DISABLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// Directed, table-driven bench for mem_access plus hand-written sequences
// for reset-while-busy and back-to-back store/load.
`default_nettype none

module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ex_waddr;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [2:0]  ex_ld_type;
  logic [31:0] ex_read_addr;
  logic        ex_ram_wreg;
  logic [31:0] ex_ram_waddr;
  logic [31:0] ex_ram_wdata;
  logic [1:0]  ex_st_type;
  logic        stall_req;
  logic        dram_req;
  logic        dram_we;
  logic [31:0] dram_addr;
  logic [3:0]  dram_be;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata;
  logic        dram_ack;
  logic [4:0]  mem_waddr;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        misalign;

  int errors = 0;
  int checks = 0;

  mem_access dut (
    .clk(clk), .rst(rst),
    .ex_waddr(ex_waddr), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_ld_type(ex_ld_type), .ex_read_addr(ex_read_addr),
    .ex_ram_wreg(ex_ram_wreg), .ex_ram_waddr(ex_ram_waddr),
    .ex_ram_wdata(ex_ram_wdata), .ex_st_type(ex_st_type),
    .stall_req(stall_req), .dram_req(dram_req), .dram_we(dram_we),
    .dram_addr(dram_addr), .dram_be(dram_be), .dram_wdata(dram_wdata),
    .dram_rdata(dram_rdata), .dram_ack(dram_ack),
    .mem_waddr(mem_waddr), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ld_type;
    logic [31:0] read_addr;
    logic        ram_wreg;
    logic [31:0] ram_waddr;
    logic [31:0] ram_wdata;
    logic [1:0]  st_type;
    logic [4:0]  waddr;
    logic        wreg;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
    logic        exp_req;
    logic        exp_mis;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic        exp_we;
    logic [31:0] exp_dwdata;
    logic        exp_mwreg;
    logic [31:0] exp_mwdata;
  } vec_t;

  vec_t vecs [13];
  logic [31:0] mem_model [16];

  function automatic vec_t mk(
    input logic [2:0] ld, input logic [31:0] ra, input logic rw,
    input logic [31:0] swa, input logic [31:0] swd, input logic [1:0] st,
    input logic [4:0] wa, input logic wr, input logic [31:0] wd,
    input int dly, input logic [31:0] rd,
    input logic req, input logic mis, input logic [31:0] ea, input logic [3:0] ebe,
    input logic ewe, input logic [31:0] edw, input logic emw, input logic [31:0] emd);
    vec_t v;
    v.ld_type = ld; v.read_addr = ra; v.ram_wreg = rw; v.ram_waddr = swa;
    v.ram_wdata = swd; v.st_type = st; v.waddr = wa; v.wreg = wr; v.wdata = wd;
    v.delay = dly; v.rdata = rd; v.exp_req = req; v.exp_mis = mis;
    v.exp_addr = ea; v.exp_be = ebe; v.exp_we = ewe; v.exp_dwdata = edw;
    v.exp_mwreg = emw; v.exp_mwdata = emd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] ld, input logic [31:0] ra, input logic rw,
                       input logic [31:0] swa, input logic [31:0] swd, input logic [1:0] st,
                       input logic [4:0] wa, input logic wr, input logic [31:0] wd);
    ex_ld_type = ld; ex_read_addr = ra; ex_ram_wreg = rw; ex_ram_waddr = swa;
    ex_ram_wdata = swd; ex_st_type = st; ex_waddr = wa; ex_wreg = wr; ex_wdata = wd;
  endtask

  task automatic idle_inputs();
    drive(3'b111, 32'h0, 1'b0, 32'h0, 32'h0, 2'b00, 5'd0, 1'b0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    drive(v.ld_type, v.read_addr, v.ram_wreg, v.ram_waddr, v.ram_wdata, v.st_type,
          v.waddr, v.wreg, v.wdata);
    dram_ack = 1'b0;
    #1;
    chk($sformatf("v%0d stall_present", idx), stall_req, v.exp_req);
    step();
    if (v.exp_req) begin
      for (int c = 0; c <= v.delay; c++) begin
        chk($sformatf("v%0d req c%0d", idx, c), dram_req, 1'b1);
        chk($sformatf("v%0d addr c%0d", idx, c), dram_addr, v.exp_addr);
        chk($sformatf("v%0d be c%0d", idx, c), dram_be, v.exp_be);
        chk($sformatf("v%0d we c%0d", idx, c), dram_we, v.exp_we);
        if (v.exp_we) chk($sformatf("v%0d dwdata c%0d", idx, c), dram_wdata, v.exp_dwdata);
        chk($sformatf("v%0d bubble c%0d", idx, c), mem_wreg, 1'b0);
        if (c == v.delay) begin
          dram_ack = 1'b1;
          dram_rdata = v.rdata;
          #1;
          chk($sformatf("v%0d stall_ack", idx), stall_req, 1'b0);
        end else begin
          chk($sformatf("v%0d stall_wait c%0d", idx, c), stall_req, 1'b1);
        end
        step();
      end
      dram_ack = 1'b0;
      dram_rdata = 32'h0;
      chk($sformatf("v%0d req_drop", idx), dram_req, 1'b0);
      chk($sformatf("v%0d mem_wreg", idx), mem_wreg, v.exp_mwreg);
      chk($sformatf("v%0d mem_waddr", idx), mem_waddr, v.waddr);
      if (!v.exp_we) chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.exp_mwdata);
    end else begin
      chk($sformatf("v%0d no_req", idx), dram_req, 1'b0);
      chk($sformatf("v%0d misalign", idx), misalign, v.exp_mis);
      chk($sformatf("v%0d mem_wreg", idx), mem_wreg, v.exp_mwreg);
      if (!v.exp_mis) begin
        chk($sformatf("v%0d mem_waddr", idx), mem_waddr, v.waddr);
        chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.exp_mwdata);
      end
    end
    idle_inputs();
    step();
    chk($sformatf("v%0d misalign_pulse_end", idx), misalign, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //             ld      raddr         rw  swaddr        swdata        st     wa  wr wdata        dly rdata          req mis addr          be       we dwdata        mwr mwdata
    vecs[0]  = mk(3'b111, 32'h0,        0, 32'h0,        32'h0,        2'b00, 5,  1, 32'h1234,     0, 32'h0,         0, 0, 32'h0,        4'b0000, 0, 32'h0,        1, 32'h1234);
    vecs[1]  = mk(3'b000, 32'h103,      0, 32'h0,        32'h0,        2'b00, 7,  1, 32'h0,        3, 32'h80FF_0011, 1, 0, 32'h100,      4'b1000, 0, 32'h0,        1, 32'hFFFF_FF80);
    vecs[2]  = mk(3'b100, 32'h103,      0, 32'h0,        32'h0,        2'b00, 8,  1, 32'h0,        3, 32'h80FF_0011, 1, 0, 32'h100,      4'b1000, 0, 32'h0,        1, 32'h0000_0080);
    vecs[3]  = mk(3'b111, 32'h0,        1, 32'h202,      32'hABCD_5678, 2'b01, 9,  1, 32'h0,        1, 32'h0,         1, 0, 32'h200,      4'b1100, 1, 32'h5678_5678, 0, 32'h0);
    vecs[4]  = mk(3'b010, 32'h305,      0, 32'h0,        32'h0,        2'b00, 10, 1, 32'h77,       0, 32'h0,         0, 1, 32'h0,        4'b0000, 0, 32'h0,        0, 32'h0);
    vecs[5]  = mk(3'b001, 32'h102,      0, 32'h0,        32'h0,        2'b00, 11, 1, 32'h0,        0, 32'h80FF_0011, 1, 0, 32'h100,      4'b1100, 0, 32'h0,        1, 32'hFFFF_80FF);
    vecs[6]  = mk(3'b101, 32'h100,      0, 32'h0,        32'h0,        2'b00, 12, 1, 32'h0,        2, 32'h80FF_8011, 1, 0, 32'h100,      4'b0011, 0, 32'h0,        1, 32'h0000_8011);
    vecs[7]  = mk(3'b111, 32'h0,        1, 32'h201,      32'h1234_56A5, 2'b00, 13, 1, 32'h0,        0, 32'h0,         1, 0, 32'h200,      4'b0010, 1, 32'hA5A5_A5A5, 0, 32'h0);
    vecs[8]  = mk(3'b111, 32'h0,        1, 32'h204,      32'hCAFE_F00D, 2'b11, 13, 0, 32'h0,        1, 32'h0,         1, 0, 32'h204,      4'b1111, 1, 32'hCAFE_F00D, 0, 32'h0);
    vecs[9]  = mk(3'b000, 32'h101,      0, 32'h0,        32'h0,        2'b00, 14, 1, 32'h0,        1, 32'h80FF_7F11, 1, 0, 32'h100,      4'b0010, 0, 32'h0,        1, 32'h0000_007F);
    vecs[10] = mk(3'b010, 32'h40,       1, 32'h55,       32'h1122_3344, 2'b00, 15, 1, 32'h0,        0, 32'h0102_0304, 1, 0, 32'h40,       4'b1111, 0, 32'h0,        1, 32'h0102_0304);
    vecs[11] = mk(3'b111, 32'h0,        1, 32'h203,      32'h1111_2222, 2'b01, 16, 1, 32'h99,       0, 32'h0,         0, 1, 32'h0,        4'b0000, 0, 32'h0,        0, 32'h0);
    vecs[12] = mk(3'b011, 32'h0,        0, 32'h0,        32'h0,        2'b00, 17, 1, 32'hBEEF,     0, 32'h0,         0, 0, 32'h0,        4'b0000, 0, 32'h0,        1, 32'hBEEF);

    for (int i = 0; i < 16; i++) mem_model[i] = 32'h0;

    rst = 1'b1;
    dram_ack = 1'b0;
    dram_rdata = 32'h0;
    idle_inputs();
    repeat (3) step();
    chk("rst dram_req", dram_req, 1'b0);
    chk("rst dram_we", dram_we, 1'b0);
    chk("rst dram_addr", dram_addr, 32'h0);
    chk("rst dram_be", dram_be, 4'b0000);
    chk("rst dram_wdata", dram_wdata, 32'h0);
    chk("rst mem_wreg", mem_wreg, 1'b0);
    chk("rst mem_waddr", mem_waddr, 5'd0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst misalign", misalign, 1'b0);
    chk("rst stall", stall_req, 1'b0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 13; i++) run_vec(i);

    // Reset while BUSY abandons the access; a late ack is ignored in IDLE.
    drive(3'b010, 32'h10, 1'b0, 32'h0, 32'h0, 2'b00, 5'd3, 1'b1, 32'h0);
    step();
    chk("rbusy req_up", dram_req, 1'b1);
    rst = 1'b1;
    idle_inputs();
    step();
    chk("rbusy req_drop", dram_req, 1'b0);
    chk("rbusy mem_wreg", mem_wreg, 1'b0);
    rst = 1'b0;
    drive(3'b111, 32'h0, 1'b0, 32'h0, 32'h0, 2'b00, 5'd9, 1'b1, 32'h55);
    dram_ack = 1'b1;
    dram_rdata = 32'h1234_5678;
    #1;
    chk("late_ack stall", stall_req, 1'b0);
    step();
    dram_ack = 1'b0;
    chk("late_ack req", dram_req, 1'b0);
    chk("late_ack mem_wreg", mem_wreg, 1'b1);
    chk("late_ack mem_waddr", mem_waddr, 5'd9);
    chk("late_ack mem_wdata", mem_wdata, 32'h55);
    idle_inputs();
    step();

    // Back-to-back SW then LW through a small word memory model, ack on first req cycle.
    drive(3'b111, 32'h0, 1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 5'd0, 1'b0, 32'h0);
    #1;
    chk("b2b sw stall", stall_req, 1'b1);
    step();
    chk("b2b sw req", dram_req, 1'b1);
    chk("b2b sw we", dram_we, 1'b1);
    chk("b2b sw addr", dram_addr, 32'h10);
    chk("b2b sw be", dram_be, 4'b1111);
    chk("b2b sw wdata", dram_wdata, 32'hDEAD_BEEF);
    for (int b = 0; b < 4; b++)
      if (dram_be[b]) mem_model[dram_addr[5:2]][8*b +: 8] = dram_wdata[8*b +: 8];
    dram_ack = 1'b1;
    #1;
    chk("b2b sw stall_ack", stall_req, 1'b0);
    step();
    dram_ack = 1'b0;
    chk("b2b sw req_drop", dram_req, 1'b0);
    chk("b2b sw mem_wreg", mem_wreg, 1'b0);
    drive(3'b010, 32'h10, 1'b0, 32'h0, 32'h0, 2'b00, 5'd20, 1'b1, 32'h0);
    #1;
    chk("b2b lw stall", stall_req, 1'b1);
    step();
    chk("b2b lw req", dram_req, 1'b1);
    chk("b2b lw we", dram_we, 1'b0);
    chk("b2b lw addr", dram_addr, 32'h10);
    chk("b2b lw be", dram_be, 4'b1111);
    dram_rdata = mem_model[dram_addr[5:2]];
    dram_ack = 1'b1;
    step();
    dram_ack = 1'b0;
    idle_inputs();
    chk("b2b lw mem_wreg", mem_wreg, 1'b1);
    chk("b2b lw mem_waddr", mem_waddr, 5'd20);
    chk("b2b lw mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
